// File: rtl/adc_pkg.sv
// Shared constants for the ADC sample scheduler: word widths and FSM state encoding.
package adc_pkg;

    localparam int unsigned ADC_W = 10;
    localparam int unsigned ACC_W = 13;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    // Number of conversions averaged for a given oversample exponent.
    function automatic logic [CNT_W-1:0] osr_samples(input logic [1:0] osr);
        return CNT_W'(1) << osr;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-period counter; tick marks the last cycle of each period.
module sample_tick_gen #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_eff;
    logic                last;

    always_comb begin
        period_eff = (period_i < PERIOD_W'(2)) ? PERIOD_W'(2) : period_i;
        // >= keeps the counter bounded if the period shrinks mid-count
        last       = (cnt_q >= period_eff - PERIOD_W'(1));
        tick_o     = enable_i & last;
        if (!enable_i || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Schedules periodic ADC conversions, averages 2^osr results per channel and
// flags overruns and conversion timeouts.
module adc_sample_scheduler
    import adc_pkg::*;
#(
    parameter int unsigned PERIOD_W    = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [1:0]          osr_i,
    input  logic                clear_i,
    output logic                start_o,
    input  logic                valid_i,
    input  logic [ADC_W-1:0]    ch0_word_i,
    input  logic [ADC_W-1:0]    ch1_word_i,
    output logic [ADC_W-1:0]    ch0_avg_o,
    output logic [ADC_W-1:0]    ch1_avg_o,
    output logic                avg_valid_o,
    output logic                overrun_o,
    output logic                timeout_o,
    output logic                busy_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic             tick;
    logic [1:0]       state_q, state_d;
    logic             start_q, start_d;
    logic             avg_valid_q, avg_valid_d;
    logic [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic [ACC_W-1:0] sum0, sum1;
    logic [CNT_W-1:0] smp_q, smp_d, smp_inc;
    logic [1:0]       osr_q, osr_d, osr_cur;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wd_last;
    logic [ADC_W-1:0] ch0_avg_q, ch0_avg_d, ch1_avg_q, ch1_avg_d;
    logic             overrun_q, overrun_d, ovr_set;
    logic             timeout_q, timeout_d, to_set;

    sample_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable_i),
        .period_i (period_i),
        .tick_o   (tick)
    );

    always_comb begin
        // osr follows the input only while no average is in progress
        osr_cur = (smp_q == '0) ? osr_i : osr_q;
        osr_d   = osr_cur;
        sum0    = acc0_q + ACC_W'(ch0_word_i);
        sum1    = acc1_q + ACC_W'(ch1_word_i);
        smp_inc = smp_q + CNT_W'(1);
        wd_last = (wd_q == WD_W'(TIMEOUT_CYC - 1));

        state_d     = state_q;
        start_d     = 1'b0;
        avg_valid_d = 1'b0;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        smp_d       = smp_q;
        wd_d        = '0;
        ch0_avg_d   = ch0_avg_q;
        ch1_avg_d   = ch1_avg_q;
        ovr_set     = 1'b0;
        to_set      = 1'b0;

        if (!enable_i) begin
            state_d = ST_IDLE;
            acc0_d  = '0;
            acc1_d  = '0;
            smp_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (tick) begin
                        start_d = 1'b1;
                        state_d = ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    ovr_set = tick;
                    if (valid_i) begin
                        acc0_d = sum0;
                        acc1_d = sum1;
                        smp_d  = smp_inc;
                        if (smp_inc == osr_samples(osr_cur)) begin
                            // Averages are registered here so they are stable while avg_valid_o is high
                            ch0_avg_d   = ADC_W'(sum0 >> osr_cur);
                            ch1_avg_d   = ADC_W'(sum1 >> osr_cur);
                            avg_valid_d = 1'b1;
                            state_d     = ST_PUBLISH;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else if (wd_last) begin
                        to_set  = 1'b1;
                        acc0_d  = '0;
                        acc1_d  = '0;
                        smp_d   = '0;
                        state_d = ST_ARMED;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                ST_PUBLISH: begin
                    ovr_set = tick;
                    acc0_d  = '0;
                    acc1_d  = '0;
                    smp_d   = '0;
                    state_d = ST_ARMED;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        overrun_d = (overrun_q & ~clear_i) | ovr_set;
        timeout_d = (timeout_q & ~clear_i) | to_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            avg_valid_q <= 1'b0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            smp_q       <= '0;
            osr_q       <= '0;
            wd_q        <= '0;
            ch0_avg_q   <= '0;
            ch1_avg_q   <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            avg_valid_q <= avg_valid_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            smp_q       <= smp_d;
            osr_q       <= osr_d;
            wd_q        <= wd_d;
            ch0_avg_q   <= ch0_avg_d;
            ch1_avg_q   <= ch1_avg_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign start_o     = start_q;
    assign avg_valid_o = avg_valid_q;
    assign ch0_avg_o   = ch0_avg_q;
    assign ch1_avg_o   = ch1_avg_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = (state_q == ST_CONVERT);

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench: stimulus queues expected start/average events, monitors pop and compare.
module tb_adc_sample_scheduler;

    typedef struct {
        int         cyc;
        logic [9:0] a0;
        logic [9:0] a1;
    } avg_t;

    typedef struct {
        logic [9:0] w0;
        logic [9:0] w1;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [15:0] period_i;
    logic [1:0]  osr_i;
    logic        clear_i;
    logic        start_o;
    logic        valid_i;
    logic [9:0]  ch0_word_i, ch1_word_i;
    logic [9:0]  ch0_avg_o, ch1_avg_o;
    logic        avg_valid_o, overrun_o, timeout_o, busy_o;

    logic        resp_valid = 1'b0;
    logic        stray_valid = 1'b0;
    logic        resp_on = 1'b1;
    int          resp_delay = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    int          exp_start[$];
    avg_t        exp_avg[$];
    word_t       word_q[$];
    avg_t        mon_e;
    word_t       rw;
    int          sc;
    int          rd;

    assign valid_i = resp_valid | stray_valid;

    adc_sample_scheduler #(
        .PERIOD_W    (16),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .period_i    (period_i),
        .osr_i       (osr_i),
        .clear_i     (clear_i),
        .start_o     (start_o),
        .valid_i     (valid_i),
        .ch0_word_i  (ch0_word_i),
        .ch1_word_i  (ch1_word_i),
        .ch0_avg_o   (ch0_avg_o),
        .ch1_avg_o   (ch1_avg_o),
        .avg_valid_o (avg_valid_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_starts(input int first, input int step, input int n);
        for (int i = 0; i < n; i++) exp_start.push_back(first + i * step);
    endtask

    task automatic push_word(input logic [9:0] w0, input logic [9:0] w1);
        word_t w;
        w.w0 = w0;
        w.w1 = w1;
        word_q.push_back(w);
    endtask

    task automatic push_avg(input int c, input logic [9:0] a0, input logic [9:0] a1);
        avg_t a;
        a.cyc = c;
        a.a0  = a0;
        a.a1  = a1;
        exp_avg.push_back(a);
    endtask

    // ADC model: answers each start_o after resp_delay cycles with the next queued words
    initial begin
        ch0_word_i = '0;
        ch1_word_i = '0;
        forever begin
            @(negedge clk);
            if (start_o && resp_on) begin
                rd = resp_delay;
                if (word_q.size() > 0) rw = word_q.pop_front();
                else begin
                    rw.w0 = '0;
                    rw.w1 = '0;
                end
                repeat (rd) @(posedge clk);
                #1;
                ch0_word_i = rw.w0;
                ch1_word_i = rw.w1;
                resp_valid = 1'b1;
                @(posedge clk);
                #1;
                resp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (start_o) begin
            if (exp_start.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL start_unexpected: start_o high at cycle %0d, none required", cyc);
            end else begin
                sc = exp_start.pop_front();
                chk("start_cycle", cyc, sc);
            end
        end
    end

    always @(negedge clk) begin
        if (avg_valid_o) begin
            if (exp_avg.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL avg_unexpected: avg_valid_o high at cycle %0d, none required", cyc);
            end else begin
                mon_e = exp_avg.pop_front();
                chk("avg_cycle", cyc, mon_e.cyc);
                chk("ch0_avg", {22'd0, ch0_avg_o}, {22'd0, mon_e.a0});
                chk("ch1_avg", {22'd0, ch1_avg_o}, {22'd0, mon_e.a1});
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, start_o, 0);
        chk({tag, "_avg_valid"}, avg_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_overrun"}, overrun_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
        chk({tag, "_ch0_avg"}, ch0_avg_o, 0);
        chk({tag, "_ch1_avg"}, ch1_avg_o, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable_i = 1'b0;
        period_i = 16'd100;
        osr_i    = 2'd0;
        clear_i  = 1'b0;

        go(3);
        chk_all_zero("reset");
        go(4);
        rst_n = 1'b1;

        // Basic cadence: period 100, single sample, response after 20 cycles
        resp_delay = 20;
        push_word(10'h155, 10'h2AA);
        push_word(10'h155, 10'h2AA);
        push_starts(110, 100, 2);
        push_avg(131, 10'h155, 10'h2AA);
        push_avg(231, 10'h155, 10'h2AA);
        go(10);
        enable_i = 1'b1;
        go(120);
        chk("busy_in_convert", busy_o, 1);
        go(135);
        chk("busy_after_publish", busy_o, 0);
        go(150);
        stray_valid = 1'b1;  // valid while ARMED must be ignored
        go(151);
        stray_valid = 1'b0;
        go(240);
        enable_i = 1'b0;

        // Four-sample average; osr change mid-average must not take effect
        go(290);
        period_i   = 16'd20;
        osr_i      = 2'd2;
        resp_delay = 3;
        push_word(10'd100, 10'd1023);
        push_word(10'd101, 10'd1023);
        push_word(10'd102, 10'd1022);
        push_word(10'd103, 10'd1);
        push_starts(320, 20, 4);
        push_avg(384, 10'd101, 10'd767);
        go(300);
        enable_i = 1'b1;
        go(345);
        osr_i = 2'd0;
        go(390);
        enable_i = 1'b0;

        // Overrun: period 10, response after 15 cycles
        go(495);
        clear_i = 1'b1;
        go(496);
        clear_i    = 1'b0;
        period_i   = 16'd10;
        resp_delay = 15;
        push_word(10'h011, 10'h022);
        push_word(10'h033, 10'h044);
        push_starts(510, 20, 2);
        push_avg(526, 10'h011, 10'h022);
        push_avg(546, 10'h033, 10'h044);
        go(500);
        enable_i = 1'b1;
        go(515);
        chk("overrun_before", overrun_o, 0);
        go(521);
        chk("overrun_set", overrun_o, 1);
        go(522);
        clear_i = 1'b1;
        go(523);
        clear_i = 1'b0;
        chk("overrun_cleared", overrun_o, 0);
        go(539);
        clear_i = 1'b1;  // coincides with a dropped tick: set wins
        go(540);
        clear_i = 1'b0;
        chk("overrun_set_wins", overrun_o, 1);
        go(548);
        enable_i = 1'b0;
        go(550);
        clear_i = 1'b1;
        go(551);
        clear_i = 1'b0;

        // Timeout: no response, period 2000
        go(590);
        period_i = 16'd2000;
        resp_on  = 1'b0;
        push_starts(2600, 2000, 2);
        go(600);
        enable_i = 1'b1;
        go(3623);
        chk("timeout_before", timeout_o, 0);
        chk("busy_before_timeout", busy_o, 1);
        go(3624);
        chk("timeout_set", timeout_o, 1);
        chk("busy_after_timeout", busy_o, 0);
        go(4610);
        enable_i = 1'b0;

        // Enable dropped mid-CONVERT discards the partial average
        go(4990);
        resp_on    = 1'b1;
        period_i   = 16'd20;
        osr_i      = 2'd1;
        resp_delay = 5;
        push_word(10'd200, 10'd10);
        push_word(10'd900, 10'd900);
        push_word(10'd300, 10'd20);
        push_word(10'd301, 10'd23);
        exp_start.push_back(5020);
        exp_start.push_back(5040);
        exp_start.push_back(5070);
        exp_start.push_back(5090);
        push_avg(5096, 10'd300, 10'd21);
        go(5000);
        enable_i = 1'b1;
        go(5042);
        enable_i = 1'b0;
        go(5046);
        chk("busy_disabled", busy_o, 0);
        go(5050);
        enable_i = 1'b1;
        go(5060);
        chk("ch0_avg_hold", ch0_avg_o, 10'h033);
        chk("ch1_avg_hold", ch1_avg_o, 10'h044);
        chk("timeout_sticky", timeout_o, 1);
        go(5100);
        enable_i = 1'b0;

        // Reset during CONVERT after 5 of 8 samples
        go(5190);
        osr_i      = 2'd3;
        resp_delay = 2;
        for (int i = 0; i < 6; i++) push_word(10'd1000, 10'd500);
        push_starts(5220, 20, 6);
        go(5200);
        enable_i = 1'b1;
        go(5321);
        rst_n = 1'b0;
        go(5322);
        chk_all_zero("midreset");
        for (int i = 1; i <= 8; i++) push_word(10'(i * 10), 10'd1023);
        push_starts(5345, 20, 8);
        push_avg(5488, 10'd45, 10'd1023);
        go(5325);
        rst_n = 1'b1;
        go(5490);
        enable_i = 1'b0;

        go(5510);
        chk("starts_outstanding", exp_start.size(), 0);
        chk("avgs_outstanding", exp_avg.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
